// File: rtl/addr_fifo_sequencer.sv
// Pops host-written addresses from the driver FIFO and issues them, optionally expanded into bursts, on a valid/ready port.
// Latency: first req_valid 2 cycles after the pop strobe; one LOAD bubble between FIFO words, 1 address/cycle inside a burst.
// Backpressure: req_valid/req_addr hold until req_ready; no FIFO pop is issued while a request is pending.
module addr_fifo_sequencer #(
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active_program,
    input  logic             program_start,
    input  logic             abort_program,
    input  logic             freeze_addr_fifo,
    input  logic             send_consec_addr,
    input  logic [7:0]       consec_count,
    input  logic [31:0]      addr_fifo_dout,
    input  logic             addr_fifo_empty,
    output logic             addr_fifo_rd,
    output logic             req_valid,
    output logic [31:0]      req_addr,
    input  logic             req_ready,
    output logic             busy,
    output logic [31:0]      issued_cnt,
    output logic [CNT_W-1:0] starve_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t     state;
    logic [7:0] burst_left;
    logic       start_q;
    logic       can_pop;
    logic       accept;
    logic       last_accept;
    logic       stat_clr;
    logic       starve_qual;

    assign can_pop     = active_program && !freeze_addr_fifo && !addr_fifo_empty && !abort_program;
    assign accept      = req_valid && req_ready;
    assign last_accept = (state == ISSUE) && accept && (burst_left == 8'd0);

    // The pop strobe must coincide with the state that decides to pop, so FIFO data lands exactly in LOAD.
    assign addr_fifo_rd = reset && can_pop && ((state == IDLE) || last_accept);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            burst_left <= 8'd0;
            req_valid  <= 1'b0;
            req_addr   <= 32'd0;
            busy       <= 1'b0;
        end else if (abort_program) begin
            state      <= IDLE;
            burst_left <= 8'd0;
            req_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_pop) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    req_addr   <= addr_fifo_dout;
                    burst_left <= send_consec_addr ? consec_count : 8'd0;
                    req_valid  <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    if (accept) begin
                        if (burst_left != 8'd0) begin
                            req_addr   <= req_addr + STEP;
                            burst_left <= burst_left - 8'd1;
                        end else if (can_pop) begin
                            req_valid <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            req_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign stat_clr    = program_start && !start_q;
    assign starve_qual = active_program && (state == IDLE) && addr_fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            start_q    <= 1'b0;
            issued_cnt <= 32'd0;
            starve_cnt <= '0;
        end else begin
            start_q <= program_start;
            if (stat_clr) begin
                issued_cnt <= 32'd0;
                starve_cnt <= '0;
            end else begin
                if (accept)
                    issued_cnt <= issued_cnt + 32'd1;
                if (starve_qual && (starve_cnt != {CNT_W{1'b1}}))
                    starve_cnt <= starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
